// File: rtl/seven_seg_scan_driver.sv
// Multiplexed N-digit 7-segment scan driver with per-digit register file and anode-off blanking.
// Optional macro SEG_BRIGHTNESS_EN adds a bright[3:0] input that PWM-dims the lit anode.
module seven_seg_scan_driver #(
  parameter int DIGITS       = 4,
  parameter int PRESCALE     = 16384,
  parameter int BLANK_CYCLES = 64,
  localparam int AW          = $clog2(DIGITS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [3:0]        wr_data,
  input  logic              wr_dp,
  input  logic [DIGITS-1:0] digit_en,
`ifdef SEG_BRIGHTNESS_EN
  input  logic [3:0]        bright,
`endif
  output logic [DIGITS-1:0] an,
  output logic [6:0]        seg,
  output logic              dp,
  output logic [AW-1:0]     scan_idx,
  output logic              frame_pulse
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] SLOT_LAST  = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [AW-1:0] IDX_LAST   = AW'(DIGITS - 1);
  localparam logic [AW:0]   DIGITS_W   = (AW+1)'(DIGITS);
  localparam logic [DIGITS-1:0] ONE_HOT0 = {{(DIGITS-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  state_t                   state_r;
  state_t                   state_s;
  logic [CW-1:0]            slot_r;
  logic [AW-1:0]            cur_r;
  logic [DIGITS-1:0][3:0]   val_r;
  logic [DIGITS-1:0]        pt_r;
  logic [DIGITS-1:0]        an_s;
  logic                     lit_ok_s;
  logic                     wr_hit_s;

  // Active-low abcdefg glyph for a hex nibble, seg[6] = a.
  function automatic logic [6:0] hex_glyph(input logic [3:0] v);
    logic [6:0] g;
    case (v)
      4'h0:    g = 7'b0000001;
      4'h1:    g = 7'b1001111;
      4'h2:    g = 7'b0010010;
      4'h3:    g = 7'b0000110;
      4'h4:    g = 7'b1001100;
      4'h5:    g = 7'b0100100;
      4'h6:    g = 7'b0100000;
      4'h7:    g = 7'b0001111;
      4'h8:    g = 7'b0000000;
      4'h9:    g = 7'b0000100;
      4'hA:    g = 7'b0001000;
      4'hB:    g = 7'b1100000;
      4'hC:    g = 7'b0110001;
      4'hD:    g = 7'b1000010;
      4'hE:    g = 7'b0110000;
      4'hF:    g = 7'b0111000;
      default: g = 7'b1111111;
    endcase
    return g;
  endfunction

`ifdef SEG_BRIGHTNESS_EN
  logic [3:0] pwm_r;

  // Free-running PWM phase for brightness dimming.
  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_r <= 4'd0;
    end else begin
      pwm_r <= pwm_r + 4'd1;
    end
  end

  assign lit_ok_s = (pwm_r <= bright);
`else
  assign lit_ok_s = 1'b1;
`endif

  assign wr_hit_s = wr_en && ({1'b0, wr_addr} < DIGITS_W);

  // Slot phase: blank for the first BLANK_CYCLES cycles, then show until the slot ends.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_BLANK: begin
        if (slot_r == BLANK_LAST) state_s = ST_SHOW;
        else                      state_s = ST_BLANK;
      end
      ST_SHOW: begin
        if (slot_r == SLOT_LAST) state_s = ST_BLANK;
        else                     state_s = ST_SHOW;
      end
      default: state_s = ST_BLANK;
    endcase
  end

  // Anode pattern for the cycle being processed; registered below.
  always_comb begin
    an_s = '1;
    if (state_r == ST_SHOW && lit_ok_s) begin
      an_s = ~((ONE_HOT0 << cur_r) & digit_en);
    end else begin
      an_s = '1;
    end
  end

  // Slot counter, scan digit and phase register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_BLANK;
      slot_r  <= '0;
      cur_r   <= IDX_LAST;
    end else begin
      state_r <= state_s;
      if (slot_r == SLOT_LAST) begin
        slot_r <= '0;
        cur_r  <= (cur_r == '0) ? IDX_LAST : cur_r - AW'(1);
      end else begin
        slot_r <= slot_r + CW'(1);
        cur_r  <= cur_r;
      end
    end
  end

  // Register file; the slot-0 load reads the pre-write value on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      val_r <= '0;
      pt_r  <= '0;
    end else if (wr_hit_s) begin
      val_r[wr_addr] <= wr_data;
      pt_r[wr_addr]  <= wr_dp;
    end else begin
      val_r <= val_r;
      pt_r  <= pt_r;
    end
  end

  // Output pins; seg/dp/scan_idx latch once per slot at cycle 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      an          <= '1;
      seg         <= 7'h7F;
      dp          <= 1'b1;
      scan_idx    <= IDX_LAST;
      frame_pulse <= 1'b0;
    end else begin
      an <= an_s;
      if (slot_r == '0) begin
        seg         <= hex_glyph(val_r[cur_r]);
        dp          <= ~pt_r[cur_r];
        scan_idx    <= cur_r;
        frame_pulse <= (scan_idx == '0) && (cur_r == IDX_LAST);
      end else begin
        seg         <= seg;
        dp          <= dp;
        scan_idx    <= scan_idx;
        frame_pulse <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Randomized bench for seven_seg_scan_driver against a time-indexed reference model.
module tb_seven_seg_scan_driver;

  localparam int DIGITS   = 5;
  localparam int PRESCALE = 8;
  localparam int BLANK    = 3;
  localparam int AW       = 3;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              wr_en = 1'b0;
  logic [AW-1:0]     wr_addr = '0;
  logic [3:0]        wr_data = 4'd0;
  logic              wr_dp = 1'b0;
  logic [DIGITS-1:0] digit_en = '1;
`ifdef SEG_BRIGHTNESS_EN
  logic [3:0]        bright = 4'hF;
`endif
  logic [DIGITS-1:0] an;
  logic [6:0]        seg;
  logic              dp;
  logic [AW-1:0]     scan_idx;
  logic              frame_pulse;

  seven_seg_scan_driver #(
    .DIGITS(DIGITS), .PRESCALE(PRESCALE), .BLANK_CYCLES(BLANK)
  ) u_dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_dp(wr_dp), .digit_en(digit_en),
`ifdef SEG_BRIGHTNESS_EN
    .bright(bright),
`endif
    .an(an), .seg(seg), .dp(dp), .scan_idx(scan_idx), .frame_pulse(frame_pulse)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [6:0] glyph [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  // Model state: t counts edges since reset released.
  int                t = 0;
  logic [3:0]        m_val [DIGITS];
  logic              m_pt  [DIGITS];
  logic [DIGITS-1:0] e_an = '1;
  logic [6:0]        e_seg = 7'h7F;
  logic              e_dp = 1'b1;
  int                e_idx = DIGITS - 1;
  logic              e_fp = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    int c, s, d;
    logic [DIGITS-1:0] one;
    one = 1;
    if (reset) begin
      for (int i = 0; i < DIGITS; i++) begin
        m_val[i] = 4'd0;
        m_pt[i]  = 1'b0;
      end
      t = 0;
      e_an = '1; e_seg = 7'h7F; e_dp = 1'b1; e_idx = DIGITS - 1; e_fp = 1'b0;
    end else begin
      c = t % PRESCALE;
      s = t / PRESCALE;
      d = DIGITS - 1 - (s % DIGITS);
      if (c == 0) begin
        e_seg = glyph[m_val[d]];
        e_dp  = ~m_pt[d];
        e_idx = d;
        e_fp  = (s > 0) && (d == DIGITS - 1);
      end else begin
        e_fp = 1'b0;
      end
      e_an = (c < BLANK) ? '1 : ~((one << d) & digit_en);
      if (wr_en && int'(wr_addr) < DIGITS) begin
        m_val[wr_addr] = wr_data;
        m_pt[wr_addr]  = wr_dp;
      end
      t++;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check("an", 32'(an), 32'(e_an));
    check("seg", 32'(seg), 32'(e_seg));
    check("dp", 32'(dp), 32'(e_dp));
    check("scan_idx", 32'(scan_idx), e_idx);
    check("frame_pulse", 32'(frame_pulse), 32'(e_fp));
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < DIGITS; i++) begin
      m_val[i] = 4'd0;
      m_pt[i]  = 1'b0;
    end
    repeat (3) cycle();
    reset = 1'b0;
    // Directed loading, then an out-of-range write that must be ignored.
    for (int i = 0; i < DIGITS; i++) begin
      wr_en = 1'b1; wr_addr = AW'(DIGITS - 1 - i); wr_data = 4'(i + 1); wr_dp = 1'b0;
      cycle();
    end
    wr_en = 1'b1; wr_addr = 3'd6; wr_data = 4'h8; wr_dp = 1'b1;
    cycle();
    wr_en = 1'b0;
    repeat (2 * DIGITS * PRESCALE) cycle();
    for (int n = 0; n < 1400; n++) begin
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_addr = AW'($urandom_range(0, 7));
      wr_data = 4'($urandom_range(0, 15));
      wr_dp   = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 39) == 0) digit_en = DIGITS'($urandom);
      if ($urandom_range(0, 99) == 0) digit_en = '1;
      reset = (n == 700) || (n == 701) || ($urandom_range(0, 299) == 0);
      cycle();
    end
    reset = 1'b0; wr_en = 1'b0;
    repeat (DIGITS * PRESCALE) cycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
